// File: rtl/rr_mux_arbiter.sv
// N-input valid/ready multiplexer with a round-robin or fixed-priority arbiter
// feeding a single registered output stage.
module rr_mux_arbiter #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned N     = 4,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             load_en;
    logic             any_valid;
    logic             grant;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             fp_found;
    logic [SELW-1:0]  fp_idx;
    logic [SELW-1:0]  winner;
    logic [WIDTH-1:0] sel_word;

    assign load_en   = !out_valid_q || out_ready;
    assign any_valid = |in_valid;
    // Reset low blocks every grant so nothing is accepted while the block is held.
    assign grant     = load_en && any_valid && Rst_n;

    // Round-robin search starting at ptr and wrapping at N (not at 2**SELW).
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!rr_found && in_valid[SELW'(idx)]) begin
                rr_found = 1'b1;
                rr_idx   = SELW'(idx);
            end
        end
    end

    // Fixed priority: lowest asserted index wins.
    always_comb begin
        fp_found = 1'b0;
        fp_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!fp_found && in_valid[i]) begin
                fp_found = 1'b1;
                fp_idx   = SELW'(i);
            end
        end
    end

    assign winner = mode ? fp_idx : rr_idx;

    // Word mux and one-hot ready from the winning index.
    always_comb begin
        sel_word = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner == SELW'(i)) begin
                sel_word    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = grant;
            end
        end
    end

    // Output stage and pointer next-state.
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = any_valid;
        end
        if (grant) begin
            out_data_d = sel_word;
            out_src_d  = winner;
            if (!mode) begin
                ptr_d = (winner == SELW'(N - 1)) ? '0 : winner + SELW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a 4-channel and a 3-channel instance
// share clock and reset; each task checks its scenario against hand values.
module tb_rr_mux_arbiter;

    logic        Clk;
    logic        Rst_n;

    logic [19:0] in_data4;
    logic [3:0]  in_valid4;
    logic [3:0]  in_ready4;
    logic        mode4;
    logic [4:0]  out_data4;
    logic [1:0]  out_src4;
    logic        out_valid4;
    logic        out_ready4;

    logic [14:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [4:0]  out_data3;
    logic [1:0]  out_src3;
    logic        out_valid3;
    logic        out_ready3;

    int total;
    int bad;

    logic [4:0] w4 [4];

    rr_mux_arbiter #(.WIDTH(5), .N(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode4),
        .out_data(out_data4), .out_src(out_src4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    rr_mux_arbiter #(.WIDTH(5), .N(3)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3),
        .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst_n      = 1'b0;
        in_valid4  = 4'b0000;
        in_valid3  = 3'b000;
        mode4      = 1'b0;
        mode3      = 1'b0;
        out_ready4 = 1'b1;
        out_ready3 = 1'b1;
        step();
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n      = 1'b0;
        in_valid4  = 4'b0000;
        out_ready4 = 1'b1;
        mode4      = 1'b0;
        step();
        step();
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid4); end
        total++; if (out_data4 !== 5'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data4); end
        total++; if (out_src4 !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", out_src4); end
        Rst_n     = 1'b1;
        in_valid4 = 4'b1111;
        step();
        total++; if (out_src4 !== 2'd0 || out_valid4 !== 1'b1 || out_data4 !== w4[0]) begin bad++; $display("FAIL reset_first src=%0d v=%b d=%h exp src=0 v=1 d=%h", out_src4, out_valid4, out_data4, w4[0]); end
        step();
        total++; if (out_src4 !== 2'd1) begin bad++; $display("FAIL reset_second got=%0d exp=1", out_src4); end
        // Pull reset between edges while all inputs are still requesting.
        #2;
        Rst_n = 1'b0;
        #1;
        total++; if (out_valid4 !== 1'b0 || out_src4 !== 2'd0 || out_data4 !== 5'h00) begin bad++; $display("FAIL reset_async v=%b src=%0d d=%h exp v=0 src=0 d=00", out_valid4, out_src4, out_data4); end
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready4); end
        step();
        Rst_n = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL reset_release_ready got=%b exp=0001", in_ready4); end
        step();
        total++; if (out_src4 !== 2'd0 || out_valid4 !== 1'b1) begin bad++; $display("FAIL reset_release_src src=%0d v=%b exp src=0 v=1", out_src4, out_valid4); end
    endtask

    task automatic test_single();
        apply_reset();
        in_valid4 = 4'b0100;
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", in_ready4); end
        step();
        total++; if (out_data4 !== 5'h15 || out_src4 !== 2'd2 || out_valid4 !== 1'b1) begin bad++; $display("FAIL single_out d=%h src=%0d v=%b exp d=15 src=2 v=1", out_data4, out_src4, out_valid4); end
        in_valid4 = 4'b1111;
        #1;
        total++; if (in_ready4 !== 4'b1000) begin bad++; $display("FAIL single_ptr3 got=%b exp=1000", in_ready4); end
        step();
        total++; if (out_src4 !== 2'd3 || out_data4 !== w4[3]) begin bad++; $display("FAIL single_next src=%0d d=%h exp src=3 d=%h", out_src4, out_data4, w4[3]); end
    endtask

    task automatic test_rr_fair();
        apply_reset();
        in_valid4 = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            total++; if (out_src4 !== 2'(k % 4) || out_valid4 !== 1'b1 || out_data4 !== w4[k % 4]) begin bad++; $display("FAIL rr_seq k=%0d src=%0d v=%b d=%h exp src=%0d v=1 d=%h", k, out_src4, out_valid4, out_data4, k % 4, w4[k % 4]); end
        end
    endtask

    task automatic test_fixed();
        apply_reset();
        in_valid4 = 4'b1111;
        step();
        mode4 = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0001) begin bad++; $display("FAIL fixed_ready got=%b exp=0001", in_ready4); end
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (out_src4 !== 2'd0 || out_valid4 !== 1'b1) begin bad++; $display("FAIL fixed_src0 k=%0d src=%0d v=%b exp src=0 v=1", k, out_src4, out_valid4); end
        end
        in_valid4 = 4'b1110;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL fixed_drop0_ready got=%b exp=0010", in_ready4); end
        step();
        total++; if (out_src4 !== 2'd1) begin bad++; $display("FAIL fixed_drop0_src got=%0d exp=1", out_src4); end
        // Back to round-robin: ptr was left at 1 by the last rr grant.
        mode4     = 1'b0;
        in_valid4 = 4'b1111;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL fixed_resume_ready got=%b exp=0010", in_ready4); end
        step();
        total++; if (out_src4 !== 2'd1) begin bad++; $display("FAIL fixed_resume_src got=%0d exp=1", out_src4); end
        step();
        total++; if (out_src4 !== 2'd2) begin bad++; $display("FAIL fixed_resume_next got=%0d exp=2", out_src4); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_valid4 = 4'b1111;
        step();
        out_ready4 = 1'b0;
        #1;
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL bp_ready got=%b exp=0000", in_ready4); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (out_src4 !== 2'd0 || out_data4 !== w4[0] || out_valid4 !== 1'b1 || in_ready4 !== 4'b0000) begin bad++; $display("FAIL bp_hold k=%0d src=%0d d=%h v=%b rdy=%b exp src=0 d=%h v=1 rdy=0000", k, out_src4, out_data4, out_valid4, in_ready4, w4[0]); end
        end
        out_ready4 = 1'b1;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready4); end
        step();
        total++; if (out_src4 !== 2'd1 || out_valid4 !== 1'b1 || out_data4 !== w4[1]) begin bad++; $display("FAIL bp_no_bubble src=%0d v=%b d=%h exp src=1 v=1 d=%h", out_src4, out_valid4, out_data4, w4[1]); end
    endtask

    task automatic test_idle();
        apply_reset();
        in_valid4 = 4'b0100;
        step();
        in_valid4 = 4'b0000;
        #1;
        total++; if (in_ready4 !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b exp=0000", in_ready4); end
        step();
        total++; if (out_valid4 !== 1'b0 || out_data4 !== 5'h15 || out_src4 !== 2'd2) begin bad++; $display("FAIL idle_hold v=%b d=%h src=%0d exp v=0 d=15 src=2", out_valid4, out_data4, out_src4); end
    endtask

    task automatic test_wrap();
        apply_reset();
        in_valid3 = 3'b010;
        step();
        total++; if (out_src3 !== 2'd1 || out_data3 !== 5'h0C) begin bad++; $display("FAIL wrap3_setup src=%0d d=%h exp src=1 d=0c", out_src3, out_data3); end
        in_valid3 = 3'b101;
        #1;
        total++; if (in_ready3 !== 3'b100) begin bad++; $display("FAIL wrap3_ready2 got=%b exp=100", in_ready3); end
        step();
        total++; if (out_src3 !== 2'd2 || out_data3 !== 5'h11) begin bad++; $display("FAIL wrap3_src2 src=%0d d=%h exp src=2 d=11", out_src3, out_data3); end
        total++; if (in_ready3 !== 3'b001) begin bad++; $display("FAIL wrap3_ready0 got=%b exp=001", in_ready3); end
        step();
        total++; if (out_src3 !== 2'd0 || out_data3 !== 5'h03) begin bad++; $display("FAIL wrap3_src0 src=%0d d=%h exp src=0 d=03", out_src3, out_data3); end
        in_valid3 = 3'b111;
        #1;
        total++; if (in_ready3 !== 3'b010) begin bad++; $display("FAIL wrap3_ptr1 got=%b exp=010", in_ready3); end

        in_valid4 = 4'b0100;
        step();
        in_valid4 = 4'b0010;
        #1;
        total++; if (in_ready4 !== 4'b0010) begin bad++; $display("FAIL wrap4_ready1 got=%b exp=0010", in_ready4); end
        step();
        total++; if (out_src4 !== 2'd1) begin bad++; $display("FAIL wrap4_src1 got=%0d exp=1", out_src4); end
        in_valid4 = 4'b1111;
        #1;
        total++; if (in_ready4 !== 4'b0100) begin bad++; $display("FAIL wrap4_ptr2 got=%b exp=0100", in_ready4); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        w4[0] = 5'h01;
        w4[1] = 5'h0A;
        w4[2] = 5'h15;
        w4[3] = 5'h1E;
        in_data4   = {5'h1E, 5'h15, 5'h0A, 5'h01};
        in_data3   = {5'h11, 5'h0C, 5'h03};
        Rst_n      = 1'b0;
        in_valid4  = 4'b0000;
        in_valid3  = 3'b000;
        mode4      = 1'b0;
        mode3      = 1'b0;
        out_ready4 = 1'b1;
        out_ready3 = 1'b1;
        #2;

        test_reset();
        test_single();
        test_rr_fair();
        test_fixed();
        test_backpressure();
        test_idle();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
